rtc_timer: RTL

- Parametrised real-time clock / timer core for the FPGA clock design.
- Generates a 1 Hz tick enable from the system clock with a prescaler. No derived clocks: all logic is on `clk`.
- Keeps an hh:mm:ss value that counts up (stopwatch with target alarm) or down (countdown to zero).
- Provides start/stop/clear/load control, a sticky done flag and a per-second tick pulse for display and alarm logic.

---
 rtl/rtc_pkg.sv | 17 +
 rtl/rtc_prescaler.sv | 29 ++
 rtl/rtc_timer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// Shared types and constants for the rtc_timer core.
package rtc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause,
    StDone
  } rtc_state_e;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

endpackage

// File: rtl/rtc_prescaler.sv
// Divides clk down to a once-per-second terminal count; counts only while enabled.
module rtc_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  // Terminal count is raw; the caller qualifies it with its own enable.
  assign tc = (cnt_q == CntMax);

  // Count 0..TICK_DIV-1 while enabled, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tc ? '0 : cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/rtc_timer.sv
// hh:mm:ss real-time clock / timer: up-count with alarm target or countdown to zero.
module rtc_timer
  import rtc_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned HR_W     = 5,
  parameter int unsigned MAX_HR   = 23
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic            clear,
  input  logic            mode,
  input  logic            load,
  input  logic [HR_W-1:0] load_hr,
  input  logic [5:0]      load_min,
  input  logic [5:0]      load_sec,
  input  logic [HR_W-1:0] tgt_hr,
  input  logic [5:0]      tgt_min,
  input  logic [5:0]      tgt_sec,
  output logic [HR_W-1:0] hr,
  output logic [5:0]      min,
  output logic [5:0]      sec,
  output logic            tick,
  output logic            running,
  output logic            done
);

  localparam logic [HR_W-1:0] HrMax  = HR_W'(MAX_HR);
  localparam logic [5:0]      MinMax = 6'(MIN_MAX);
  localparam logic [5:0]      SecMax = 6'(SEC_MAX);

  rtc_state_e      state_q, state_d;
  logic [HR_W-1:0] hr_q, hr_d, tgt_hr_q, tgt_hr_d;
  logic [5:0]      min_q, min_d, tgt_min_q, tgt_min_d;
  logic [5:0]      sec_q, sec_d, tgt_sec_q, tgt_sec_d;
  logic            mode_q, mode_d;
  logic            tick_q, tick_d;
  logic            pre_clr, pre_en, pre_tc;
  logic            load_ok;

  logic [HR_W-1:0] inc_hr, dec_hr, ld_hr;
  logic [5:0]      inc_min, dec_min, ld_min;
  logic [5:0]      inc_sec, dec_sec, ld_sec;
  logic            time_zero, dec_zero, tgt_zero, inc_hit;

  rtc_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk(clk),
    .rst(rst),
    .clr(pre_clr),
    .en (pre_en),
    .tc (pre_tc)
  );

  assign ld_hr  = (load_hr > HrMax) ? HrMax : load_hr;
  assign ld_min = (load_min > MinMax) ? MinMax : load_min;
  assign ld_sec = (load_sec > SecMax) ? SecMax : load_sec;

  assign time_zero = (hr_q == '0) && (min_q == '0) && (sec_q == '0);
  assign dec_zero  = (dec_hr == '0) && (dec_min == '0) && (dec_sec == '0);
  assign tgt_zero  = (tgt_hr_q == '0) && (tgt_min_q == '0) && (tgt_sec_q == '0);
  assign inc_hit   = (inc_hr == tgt_hr_q) && (inc_min == tgt_min_q) && (inc_sec == tgt_sec_q);

  // Candidate next times one second up and one second down, with carry/borrow.
  always_comb begin
    inc_hr  = hr_q;
    inc_min = min_q;
    inc_sec = sec_q + 6'd1;
    if (sec_q == SecMax) begin
      inc_sec = '0;
      inc_min = min_q + 6'd1;
      if (min_q == MinMax) begin
        inc_min = '0;
        inc_hr  = (hr_q == HrMax) ? '0 : hr_q + HR_W'(1);
      end
    end
    dec_hr  = hr_q;
    dec_min = min_q;
    dec_sec = sec_q - 6'd1;
    if (sec_q == '0) begin
      dec_sec = SecMax;
      dec_min = min_q - 6'd1;
      if (min_q == '0) begin
        dec_min = MinMax;
        dec_hr  = hr_q - HR_W'(1);
      end
    end
  end

  // Next-state and datapath update; priority clear > stop > start > load.
  always_comb begin
    state_d   = state_q;
    hr_d      = hr_q;
    min_d     = min_q;
    sec_d     = sec_q;
    mode_d    = mode_q;
    tgt_hr_d  = tgt_hr_q;
    tgt_min_d = tgt_min_q;
    tgt_sec_d = tgt_sec_q;
    tick_d    = 1'b0;
    pre_clr   = 1'b0;
    pre_en    = 1'b0;
    load_ok   = 1'b0;
    if (clear) begin
      state_d = StIdle;
      hr_d    = '0;
      min_d   = '0;
      sec_d   = '0;
      pre_clr = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!stop && start) begin
            state_d   = StRun;
            pre_clr   = 1'b1;
            mode_d    = mode;
            tgt_hr_d  = tgt_hr;
            tgt_min_d = tgt_min;
            tgt_sec_d = tgt_sec;
          end else if (!stop && load) begin
            load_ok = 1'b1;
          end
        end
        StRun: begin
          if (stop) begin
            state_d = StPause;
          end else if (mode_q == MODE_DOWN && time_zero) begin
            // Countdown started at zero: finish without ever ticking.
            state_d = StDone;
          end else begin
            pre_en = 1'b1;
            if (pre_tc) begin
              tick_d = 1'b1;
              if (mode_q == MODE_UP) begin
                hr_d  = inc_hr;
                min_d = inc_min;
                sec_d = inc_sec;
                if (!tgt_zero && inc_hit) state_d = StDone;
              end else begin
                hr_d  = dec_hr;
                min_d = dec_min;
                sec_d = dec_sec;
                if (dec_zero) state_d = StDone;
              end
            end
          end
        end
        StPause: begin
          if (!stop && start) begin
            state_d = StRun;
          end else if (!stop && load) begin
            load_ok = 1'b1;
          end
        end
        StDone: begin
          if (!stop && load) load_ok = 1'b1;
        end
        default: state_d = StIdle;
      endcase
      if (load_ok) begin
        hr_d  = ld_hr;
        min_d = ld_min;
        sec_d = ld_sec;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      hr_q      <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      mode_q    <= MODE_UP;
      tgt_hr_q  <= '0;
      tgt_min_q <= '0;
      tgt_sec_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hr_q      <= hr_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      mode_q    <= mode_d;
      tgt_hr_q  <= tgt_hr_d;
      tgt_min_q <= tgt_min_d;
      tgt_sec_q <= tgt_sec_d;
      tick_q    <= tick_d;
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    running = (state_q == StRun);
    done    = (state_q == StDone);
    hr      = hr_q;
    min     = min_q;
    sec     = sec_q;
    tick    = tick_q;
  end

endmodule
